// File: rtl/vga_timing_generator.sv
// 800x600@60 raster timing generator: pixel coordinates/visibility for the framebuffer
// address path, plus sync and delayed visibility aligned to the RAM-read latency.
module vga_timing_generator #(
    parameter int   COORDINATES = 10,
    parameter int   H_VIS       = 800,
    parameter int   H_FP        = 40,
    parameter int   H_SYNC      = 128,
    parameter int   H_BP        = 88,
    parameter int   V_VIS       = 600,
    parameter int   V_FP        = 1,
    parameter int   V_SYNC      = 4,
    parameter int   V_BP        = 23,
    parameter logic H_POL       = 1'b1,
    parameter logic V_POL       = 1'b1,
    parameter int   DELAY       = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pix_en,
    output logic [COORDINATES-1:0] o_x,
    output logic [COORDINATES-1:0] o_y,
    output logic                   o_on_air,
    output logic                   o_on_air_d,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_frame_start,
    output logic                   o_line_start
);

    localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_VIS + H_FP;
    localparam int H_SYNC_HI = H_VIS + H_FP + H_SYNC - 1;
    localparam int V_SYNC_LO = V_VIS + V_FP;
    localparam int V_SYNC_HI = V_VIS + V_FP + V_SYNC - 1;

    logic [10:0]            r_h_cnt;
    logic [10:0]            r_v_cnt;
    logic [COORDINATES-1:0] r_x;
    logic [COORDINATES-1:0] r_y;
    logic                   r_on_air;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_frame_start;
    logic                   r_line_start;

    logic w_h_last;
    logic w_v_last;
    logic w_h_vis;
    logic w_v_vis;
    logic w_on_air;
    logic w_hsync_raw;
    logic w_vsync_raw;

    assign w_h_last    = (r_h_cnt == 11'(H_TOTAL - 1));
    assign w_v_last    = (r_v_cnt == 11'(V_TOTAL - 1));
    assign w_h_vis     = (r_h_cnt < 11'(H_VIS));
    assign w_v_vis     = (r_v_cnt < 11'(V_VIS));
    assign w_on_air    = w_h_vis && w_v_vis;
    assign w_hsync_raw = ((r_h_cnt >= 11'(H_SYNC_LO)) && (r_h_cnt <= 11'(H_SYNC_HI))) ? H_POL : ~H_POL;
    assign w_vsync_raw = ((r_v_cnt >= 11'(V_SYNC_LO)) && (r_v_cnt <= 11'(V_SYNC_HI))) ? V_POL : ~V_POL;

    // Outputs register a decode of the pre-increment counters, so they trail the counters by one pix_en.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_on_air      <= 1'b0;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else if (i_pix_en) begin
            r_h_cnt <= w_h_last ? 11'd0 : r_h_cnt + 11'd1;
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
            end
            r_on_air      <= w_on_air;
            r_x           <= w_on_air ? r_h_cnt[COORDINATES-1:0] : '0;
            r_y           <= w_on_air ? r_v_cnt[COORDINATES-1:0] : '0;
            r_hsync       <= w_hsync_raw;
            r_vsync       <= w_vsync_raw;
            r_frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
            r_line_start  <= (r_h_cnt == 11'd0) && w_v_vis;
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_on_air      = r_on_air;
    assign o_frame_start = r_frame_start;
    assign o_line_start  = r_line_start;

    generate
        if (DELAY > 0) begin : g_delay
            logic r_hs_pipe [DELAY];
            logic r_vs_pipe [DELAY];
            logic r_on_pipe [DELAY];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DELAY; i++) begin
                        r_hs_pipe[i] <= ~H_POL;
                        r_vs_pipe[i] <= ~V_POL;
                        r_on_pipe[i] <= 1'b0;
                    end
                end else if (i_pix_en) begin
                    r_hs_pipe[0] <= r_hsync;
                    r_vs_pipe[0] <= r_vsync;
                    r_on_pipe[0] <= r_on_air;
                    for (int i = 1; i < DELAY; i++) begin
                        r_hs_pipe[i] <= r_hs_pipe[i-1];
                        r_vs_pipe[i] <= r_vs_pipe[i-1];
                        r_on_pipe[i] <= r_on_pipe[i-1];
                    end
                end
            end

            assign o_hsync    = r_hs_pipe[DELAY-1];
            assign o_vsync    = r_vs_pipe[DELAY-1];
            assign o_on_air_d = r_on_pipe[DELAY-1];
        end else begin : g_no_delay
            assign o_hsync    = r_hsync;
            assign o_vsync    = r_vsync;
            assign o_on_air_d = r_on_air;
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a full-size instance plus two reduced-geometry instances
// (DELAY 0 and DELAY 3, inverted polarity) compared every clock against an arithmetic raster model.
module tb_vga_timing_generator;

    localparam int SH_VIS = 20, SH_FP = 3, SH_SYNC = 5, SH_BP = 4;
    localparam int SV_VIS = 10, SV_FP = 2, SV_SYNC = 3, SV_BP = 2;
    localparam int S_HT = SH_VIS + SH_FP + SH_SYNC + SH_BP;
    localparam int S_VT = SV_VIS + SV_FP + SV_SYNC + SV_BP;
    localparam int S_FRAME = S_HT * S_VT;

    typedef struct packed {
        logic       on;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       ls;
        logic       hs;
        logic       vs;
        logic       ond;
    } vga_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_on, a_ond, a_hs, a_vs, a_fs, a_ls;
    logic b_on, b_ond, b_hs, b_vs, b_fs, b_ls;
    logic c_on, c_ond, c_hs, c_vs, c_fs, c_ls;

    vga_t a_obs, b_obs, c_obs;
    assign a_obs = '{a_on, a_x, a_y, a_fs, a_ls, a_hs, a_vs, a_ond};
    assign b_obs = '{b_on, b_x, b_y, b_fs, b_ls, b_hs, b_vs, b_ond};
    assign c_obs = '{c_on, c_x, c_y, c_fs, c_ls, c_hs, c_vs, c_ond};

    longint k;      // enabled edges since reset release
    longint cyc;    // clock edges seen by tick
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    vga_timing_generator u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_x(a_x), .o_y(a_y), .o_on_air(a_on), .o_on_air_d(a_ond),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_frame_start(a_fs), .o_line_start(a_ls)
    );

    vga_timing_generator #(
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
        .H_POL(1'b1), .V_POL(1'b1), .DELAY(0)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_x(b_x), .o_y(b_y), .o_on_air(b_on), .o_on_air_d(b_ond),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_frame_start(b_fs), .o_line_start(b_ls)
    );

    vga_timing_generator #(
        .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
        .H_POL(1'b0), .V_POL(1'b0), .DELAY(3)
    ) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_x(c_x), .o_y(c_y), .o_on_air(c_on), .o_on_air_d(c_ond),
        .o_hsync(c_hs), .o_vsync(c_vs), .o_frame_start(c_fs), .o_line_start(c_ls)
    );

    // Expected outputs after k enabled edges: undelayed fields show raster pixel k-1,
    // delayed fields show pixel k-1-dly; anything before the first pixel is the idle level.
    function automatic vga_t ref_out(input longint kk, input int hv, input int hf, input int hsw,
                                     input int hb, input int vv, input int vf, input int vsw,
                                     input int vb, input logic hp, input logic vp, input int dly);
        int ht, vt, h, v;
        longint p;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        ref_out     = '0;
        ref_out.hs  = ~hp;
        ref_out.vs  = ~vp;
        if (kk > 0) begin
            p = kk - 1;
            h = int'(p % ht);
            v = int'((p / ht) % vt);
            ref_out.on = (h < hv) && (v < vv);
            ref_out.x  = ref_out.on ? 10'(h) : 10'd0;
            ref_out.y  = ref_out.on ? 10'(v) : 10'd0;
            ref_out.fs = (h == 0) && (v == 0);
            ref_out.ls = (h == 0) && (v < vv);
        end
        if (kk > dly) begin
            p = kk - 1 - dly;
            h = int'(p % ht);
            v = int'((p / ht) % vt);
            ref_out.hs  = (h >= hv + hf && h < hv + hf + hsw) ? hp : ~hp;
            ref_out.vs  = (v >= vv + vf && v < vv + vf + vsw) ? vp : ~vp;
            ref_out.ond = (h < hv) && (v < vv);
        end
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic check_all();
        check_val("A", 32'(a_obs), 32'(ref_out(k, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 2)));
        check_val("B", 32'(b_obs), 32'(ref_out(k, SH_VIS, SH_FP, SH_SYNC, SH_BP,
                                               SV_VIS, SV_FP, SV_SYNC, SV_BP, 1'b1, 1'b1, 0)));
        check_val("C", 32'(c_obs), 32'(ref_out(k, SH_VIS, SH_FP, SH_SYNC, SH_BP,
                                               SV_VIS, SV_FP, SV_SYNC, SV_BP, 1'b0, 1'b0, 3)));
    endtask

    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        cyc++;
        if (en && rst_n) k++;
        #1;
        check_all();
    endtask

    // Assert reset between edges, confirm it takes effect without a clock, then release.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        k = 0;
        check_all();
        check_val("rst_a_hs", 32'(a_hs), 32'd0);
        check_val("rst_c_hs", 32'(c_hs), 32'd1);
        tick(1'b1);
        tick(1'b0);
        rst_n = 1'b1;
        tick(1'b1);
        check_val("restart_a_fs", 32'(a_fs), 32'd1);
        check_val("restart_b_xy", 32'({b_on, b_x, b_y}), 32'({1'b1, 10'd0, 10'd0}));
        $display("reset: async assert/release done, restarted at pixel (0,0)");
    endtask

    initial begin
        int r1, r2, hs_high, ls_cnt, vs_cnt, fs_cnt, f1, f2, found;
        logic prev_hs, prev_fs;
        rst_n  = 1'b0;
        pix_en = 1'b0;
        k      = 0;
        cyc    = 0;

        repeat (3) tick(1'b1);
        check_val("reset_a", 32'(a_obs), 32'({1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        $display("reset: held 3 clocks, outputs at idle levels");
        rst_n = 1'b1;

        // First line on the full-size instance, continuous enable.
        tick(1'b1);
        check_val("first_a", 32'({a_on, a_x, a_y, a_fs, a_ls}), 32'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1}));
        r1 = -1; r2 = -1; hs_high = 0; prev_hs = a_hs;
        for (int i = 2; i <= 3 * 1056; i++) begin
            tick(1'b1);
            if (i == 800) check_val("a_x_799", 32'(a_x), 32'd799);
            if (i == 801) check_val("a_on_801", 32'(a_on), 32'd0);
            if (a_hs && !prev_hs) begin
                if (r1 < 0) r1 = int'(k);
                else if (r2 < 0) r2 = int'(k);
            end
            if (r1 >= 0 && r2 < 0 && a_hs) hs_high++;
            prev_hs = a_hs;
        end
        check_val("a_hs_rise", 32'(r1), 32'(1 + 840 + 2));
        check_val("a_hs_period", 32'(r2 - r1), 32'd1056);
        check_val("a_hs_width", 32'(hs_high), 32'd128);
        $display("line: hsync rise=%0d period=%0d width=%0d", r1, r2 - r1, hs_high);

        // Frame statistics on the reduced instance, aligned to a frame_start.
        found = 0;
        for (int i = 0; i < S_FRAME + 2 && found == 0; i++) begin
            tick(1'b1);
            if (b_fs) found = 1;
        end
        check_val("b_fs_seen", 32'(found), 32'd1);
        ls_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            if (b_ls) ls_cnt++;
            if (b_vs) vs_cnt++;
            if (b_fs) fs_cnt++;
            tick(1'b1);
        end
        check_val("b_ls_per_frame", 32'(ls_cnt), 32'(SV_VIS));
        check_val("b_vs_per_frame", 32'(vs_cnt), 32'(SV_SYNC * S_HT));
        check_val("b_fs_per_frame", 32'(fs_cnt), 32'd1);
        check_val("b_fs_repeat", 32'(b_fs), 32'd1);
        $display("frame: line_start=%0d vsync_cycles=%0d frame_start=%0d", ls_cnt, vs_cnt, fs_cnt);

        // Enable on one clock of every two.
        repeat (10) begin tick(1'b1); tick(1'b0); end
        fs_cnt = 0; f1 = -1; f2 = -1; prev_fs = b_fs;
        for (int i = 0; i < 3 * S_FRAME; i++) begin
            tick(1'b1);
            if (b_fs) fs_cnt++;
            if (b_fs && !prev_fs) begin if (f1 < 0) f1 = int'(cyc); else if (f2 < 0) f2 = int'(cyc); end
            prev_fs = b_fs;
            tick(1'b0);
            if (b_fs) fs_cnt++;
            prev_fs = b_fs;
        end
        check_val("half_fs_clks", 32'(fs_cnt), 32'd6);
        check_val("half_frame_clk", 32'(f2 - f1), 32'(2 * S_FRAME));
        $display("half-rate: frame period=%0d clk, frame_start high %0d clk over 3 frames", f2 - f1, fs_cnt);

        // Random enable with an asynchronous reset dropped mid-frame.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            if (i == 1200 + int'($urandom_range(0, 300)) && i < 1500) async_reset();
        end
        async_reset();
        for (int i = 0; i < 1500; i++) tick(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        $display("random: enable pattern done, k=%0d", k);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Generates 800x600 @ 60 Hz raster timing (40 MHz pixel rate) and drives the pixel coordinate/visibility inputs of the framebuffer-to-RGB stage directly downstream. It produces the x/y/on_air triple that the buffer manager turns into a framebuffer address, plus hsync/vsync/on_air_d outputs delayed by a fixed number of pixel cycles. The delay aligns the sync pulses and the delayed visibility flag with RGB that returns after the registered-address and RAM-read latency.

## Interface
- COORDINATES, 10: width of x/y outputs.
- H_VIS, 800: visible pixels per line.
- H_FP, 40: horizontal front porch.
- H_SYNC, 128: horizontal sync width.
- H_BP, 88: horizontal back porch; line total 1056.
- V_VIS, 600: visible lines.
- V_FP, 1: vertical front porch.
- V_SYNC, 4: vertical sync width.
- V_BP, 23: vertical back porch; frame total 628.
- H_POL, 1: hsync active level.
- V_POL, 1: vsync active level.
- DELAY, 2: pixel-enable cycles of delay applied to hsync/vsync/on_air_d (0 allowed).
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- pix_en  input  1  pixel-rate enable; all state advances only when high.
- x  output  COORDINATES  visible column, 0 outside the visible region.
- y  output  COORDINATES  visible row, 0 outside the visible region.
- on_air  output  1  high when (x,y) is a visible pixel; aligned with x/y.
- on_air_d  output  1  on_air delayed DELAY pix_en cycles (blanking gate for RGB).
- hsync  output  1  horizontal sync, delayed DELAY pix_en cycles.
- vsync  output  1  vertical sync, delayed DELAY pix_en cycles.
- frame_start  output  1  one-pix_en pulse coincident with pixel (0,0).
- line_start  output  1  one-pix_en pulse coincident with x=0 of each visible line.

## Operation
- Internal h_cnt (0..1055) and v_cnt (0..627) are 11 bits wide, independent of COORDINATES.
- On each pix_en:
  - h_cnt increments, wrapping 1055->0.
  - On that wrap, v_cnt increments, wrapping 627->0.
- Output registers load, on the same pix_en, a decode of the pre-increment counters:
  - on_air = (h_cnt < H_VIS) && (v_cnt < V_VIS).
  - x = on_air ? h_cnt[COORDINATES-1:0] : 0.
  - y = on_air ? v_cnt[COORDINATES-1:0] : 0.
  - hsync_raw active for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] (840..967).
  - vsync_raw active for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] (601..604), over whole lines.
  - frame_start = (h_cnt==0 && v_cnt==0).
  - line_start = (h_cnt==0 && v_cnt<V_VIS).
- Delay line: hsync_raw, vsync_raw and on_air pass through a DELAY-stage shift register that advances only on pix_en; its last stage drives hsync/vsync/on_air_d. With DELAY=0 these outputs equal the undelayed registered values.
- pix_en low: counters, output registers and delay line hold unchanged.

## Timing
- Reset (asynchronous assert, any time including mid-frame): h_cnt=0, v_cnt=0, x=0, y=0, on_air=0, on_air_d=0, frame_start=0, line_start=0, hsync=~H_POL, vsync=~V_POL. All delay stages are set to the inactive level.
- Release: synchronous to clk. The first pix_en after release outputs pixel (0,0) with on_air=1 and frame_start=1.
- Latency, counter to undelayed outputs: 1 pix_en. Undelayed to delayed outputs: DELAY further pix_en.
- Line period: 1056 pix_en cycles. Frame period: 663168 pix_en cycles.
- frame_start and line_start are exactly one pix_en wide: they stay high until the next pix_en, so with pix_en duty <100% they span several clk cycles.
- Simultaneous h and v wrap at (1055,627) -> (0,0) in one step, with no lost or duplicate line.

## Test plan
- Reset, pix_en=1 continuous, DELAY=0 -> first enabled cycle x=0, y=0, on_air=1, frame_start=1; x=799 on the 800th cycle; on_air=0 on cycle 801.
- Count hsync over one line -> active for 128 consecutive pix_en, rising 840 cycles after line_start, period 1056.
- Run a full frame -> vsync active for 4x1056 cycles starting at line 601; frame_start repeats every 663168 cycles; line_start fires 600 times per frame.
- DELAY=2 -> hsync/vsync/on_air_d equal the DELAY=0 waveforms shifted by exactly 2 pix_en; x/y/on_air are unshifted.
- pix_en toggling 1-of-2 clk -> each output value persists 2 clk; frame period is 1326336 clk; frame_start is high 2 clk.
- Assert rst_n low at (x=400, y=300) -> all outputs reach reset values immediately; after release, output restarts at (0,0) with frame_start=1.
